// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package cu_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned IMM_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        LUI    = 4'd11,
        TRAP   = 4'd12
    } state_t;

    // Operation class handed to the ALU decoder
    typedef enum logic [2:0] {
        AM_ADD   = 3'd0,
        AM_SUB   = 3'd1,
        AM_PASSB = 3'd2,
        AM_R     = 3'd3,
        AM_I     = 3'd4
    } alu_mode_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd10;

    localparam logic [IMM_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_W-1:0] IMM_U = 3'd3;
    localparam logic [IMM_W-1:0] IMM_J = 3'd4;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/mc_control_unit_if.sv
// Instruction fields, ALU flags, memory handshake and datapath selects.
interface mc_control_unit_if #(
    parameter int unsigned ALU_CTRL_W = 4
);
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic                  zero;
    logic                  lt;
    logic                  ltu;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  mem_write;
    logic                  adr_src;
    logic                  ir_write;
    logic                  pc_write;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [2:0]            imm_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [1:0]            result_src;
    logic                  reg_write;

    // Control unit side
    modport master (
        input  opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write,
               alu_src_a, alu_src_b, imm_src, alu_ctrl, result_src, reg_write
    );

    // Datapath / memory side
    modport slave (
        output opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write,
               alu_src_a, alu_src_b, imm_src, alu_ctrl, result_src, reg_write
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational mapping of operation class and funct fields to an ALU op.
module alu_decoder
    import cu_pkg::*;
(
    input  alu_mode_t           mode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    output logic [ALU_OP_W-1:0] alu_op_c
);

    // funct3 decode for R/I forms; only R-type uses instr[30] on 000
    always_comb begin
        alu_op_c = ALU_ADD;
        case (mode)
            AM_SUB:   alu_op_c = ALU_SUB;
            AM_PASSB: alu_op_c = ALU_PASSB;
            AM_R, AM_I: begin
                case (funct3)
                    3'b000:  alu_op_c = (mode == AM_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_c = ALU_SLL;
                    3'b010:  alu_op_c = ALU_SLT;
                    3'b011:  alu_op_c = ALU_SLTU;
                    3'b100:  alu_op_c = ALU_XOR;
                    3'b101:  alu_op_c = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_c = ALU_OR;
                    default: alu_op_c = ALU_AND;
                endcase
            end
            default:  alu_op_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback over a
// shared ALU and unified memory, with memory-wait timeout and illegal-op trap.
// Optional retired-instruction counter enabled by defining MC_CU_INSTRET_EN.
module mc_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mc_control_unit_if.master    bus,
    output logic                 fault,
    output logic [STATE_W-1:0]   state_o
`ifdef MC_CU_INSTRET_EN
    ,
    output logic [31:0]          instret
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    wait_cnt;
    logic                timeout_hit;
    logic                taken;
    logic                br_illegal;
    alu_mode_t           alu_mode;
    logic [ALU_OP_W-1:0] alu_op;

    logic       mem_req_c;
    logic       mem_write_c;
    logic       adr_src_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [2:0] imm_src_c;
    logic [1:0] result_src_c;
    logic       reg_write_c;

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    alu_decoder u_alu_decoder (
        .mode     (alu_mode),
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .alu_op_c (alu_op)
    );

    // Branch condition from comparison flags; 010/011 are not branches
    always_comb begin
        taken      = 1'b0;
        br_illegal = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = ~bus.lt;
            3'b110:  taken = bus.ltu;
            3'b111:  taken = ~bus.ltu;
            default: br_illegal = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next state and datapath controls; everything forced low while in reset
    always_comb begin
        next_state   = state;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        alu_src_a_c  = SRC_A_PC;
        alu_src_b_c  = SRC_B_RS2;
        imm_src_c    = IMM_I;
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b0;
        alu_mode     = AM_ADD;
        if (rst_n) begin
            unique case (state)
                FETCH: begin
                    mem_req_c    = 1'b1;
                    alu_src_b_c  = SRC_B_FOUR;
                    result_src_c = RES_ALU;
                    if (bus.mem_ready) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        next_state = DECODE;
                    end else if (timeout_hit) begin
                        next_state = TRAP;
                    end
                end
                DECODE: begin
                    alu_src_a_c = SRC_A_OLDPC;
                    alu_src_b_c = SRC_B_IMM;
                    imm_src_c   = IMM_B;
                    case (bus.opcode)
                        OP_LOAD, OP_STORE: next_state = MEMADR;
                        OP_R:              next_state = EXECR;
                        OP_I:              next_state = EXECI;
                        OP_BRANCH:         next_state = BRANCH;
                        OP_JAL:            next_state = JAL;
                        OP_LUI:            next_state = LUI;
                        default:           next_state = TRAP;
                    endcase
                end
                MEMADR: begin
                    alu_src_a_c = SRC_A_RS1;
                    alu_src_b_c = SRC_B_IMM;
                    if (bus.opcode == OP_STORE) begin
                        imm_src_c  = IMM_S;
                        next_state = MEMWR;
                    end else begin
                        next_state = MEMRD;
                    end
                end
                MEMRD: begin
                    mem_req_c = 1'b1;
                    adr_src_c = 1'b1;
                    if (bus.mem_ready) begin
                        next_state = MEMWB;
                    end else if (timeout_hit) begin
                        next_state = TRAP;
                    end
                end
                MEMWB: begin
                    result_src_c = RES_MEM;
                    reg_write_c  = 1'b1;
                    next_state   = FETCH;
                end
                MEMWR: begin
                    mem_req_c   = 1'b1;
                    mem_write_c = 1'b1;
                    adr_src_c   = 1'b1;
                    if (bus.mem_ready) begin
                        next_state = FETCH;
                    end else if (timeout_hit) begin
                        next_state = TRAP;
                    end
                end
                EXECR: begin
                    alu_src_a_c = SRC_A_RS1;
                    alu_src_b_c = SRC_B_RS2;
                    alu_mode    = AM_R;
                    next_state  = ALUWB;
                end
                EXECI: begin
                    alu_src_a_c = SRC_A_RS1;
                    alu_src_b_c = SRC_B_IMM;
                    imm_src_c   = IMM_I;
                    alu_mode    = AM_I;
                    next_state  = ALUWB;
                end
                ALUWB: begin
                    result_src_c = RES_ALUOUT;
                    reg_write_c  = 1'b1;
                    next_state   = FETCH;
                end
                BRANCH: begin
                    alu_src_a_c  = SRC_A_RS1;
                    alu_src_b_c  = SRC_B_RS2;
                    alu_mode     = AM_SUB;
                    result_src_c = RES_ALUOUT;
                    if (br_illegal) begin
                        next_state = TRAP;
                    end else begin
                        pc_write_c = taken;
                        next_state = FETCH;
                    end
                end
                JAL: begin
                    // PC <- target held in ALUOut; ALU forms the link value
                    alu_src_a_c  = SRC_A_OLDPC;
                    alu_src_b_c  = SRC_B_FOUR;
                    imm_src_c    = IMM_J;
                    result_src_c = RES_ALUOUT;
                    pc_write_c   = 1'b1;
                    next_state   = ALUWB;
                end
                LUI: begin
                    alu_src_b_c = SRC_B_IMM;
                    imm_src_c   = IMM_U;
                    alu_mode    = AM_PASSB;
                    next_state  = ALUWB;
                end
                TRAP: begin
                    next_state = TRAP;
                end
                default: begin
                    next_state = TRAP;
                end
            endcase
        end
    end

    // Memory wait counter; cleared by ready or any state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (next_state != state || bus.mem_ready) begin
            wait_cnt <= '0;
        end else if (mem_req_c) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Sticky fault: TRAP is only left through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else begin
            fault <= (next_state == TRAP);
        end
    end

`ifdef MC_CU_INSTRET_EN
    // Count instructions retiring back into FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'd0;
        end else if (next_state == FETCH && state != FETCH) begin
            instret <= instret + 32'd1;
        end
    end
`endif

    assign state_o        = STATE_W'(state);
    assign bus.mem_req    = mem_req_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.adr_src    = adr_src_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.imm_src    = imm_src_c;
    assign bus.alu_ctrl   = ALU_CTRL_W'(alu_op);
    assign bus.result_src = result_src_c;
    assign bus.reg_write  = reg_write_c;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: instruction table plus corner sequences.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fault;
    logic [3:0]  state_o;
`ifdef MC_CU_INSTRET_EN
    logic [31:0] instret;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_control_unit_if #(.ALU_CTRL_W(4)) bus();

    mc_control_unit #(.ALU_CTRL_W(4), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .fault   (fault),
        .state_o (state_o)
`ifdef MC_CU_INSTRET_EN
        ,
        .instret (instret)
`endif
    );

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       l;
        logic       lu;
        int         st3;   // state in the third cycle of the instruction
        int         alu;   // alu_ctrl in that cycle
        int         pcw;   // pc_write in that cycle
        int         cyc;   // cycles from FETCH to the next FETCH
        int         rw;    // cycles with reg_write high
    } vec_t;

    typedef struct {
        string name;
        int    st3;
        int    alu;
        int    pcw;
        int    cyc;
        int    rw;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Drive point: 1 ns after the falling edge, well before the next rising edge
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic l, input logic lu);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        bus.zero     = z;
        bus.lt       = l;
        bus.ltu      = lu;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic z, input logic l, input logic lu,
                                input int st3, input int alu, input int pcw,
                                input int cyc, input int rw);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.l = l; v.lu = lu;
        v.st3 = st3; v.alu = alu; v.pcw = pcw; v.cyc = cyc; v.rw = rw;
        return v;
    endfunction

    // Push expectation, run one instruction with memory always ready, pop and compare
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   cyc;
        sb_q.push_back('{v.name, v.st3, v.alu, v.pcw, v.cyc, v.rw});
        drive(v.op, v.f3, v.f7, v.z, v.l, v.lu);
        bus.mem_ready = 1'b1;
        got = '{v.name, -1, -1, -1, 0, 0};
        cyc = 0;
        forever begin
            #1;
            if (cyc > 0 && state_o == 4'd0) break;
            if (cyc >= 40) break;
            if (cyc == 2) begin
                got.st3 = int'(state_o);
                got.alu = int'(bus.alu_ctrl);
                got.pcw = int'(bus.pc_write);
            end
            got.rw += int'(bus.reg_write);
            next_cycle();
            cyc++;
        end
        got.cyc = cyc;
        e = sb_q.pop_front();
        chk({e.name, ".state"},    got.st3, e.st3);
        chk({e.name, ".alu_ctrl"}, got.alu, e.alu);
        chk({e.name, ".pc_write"}, got.pcw, e.pcw);
        chk({e.name, ".cycles"},   got.cyc, e.cyc);
        chk({e.name, ".reg_wr"},   got.rw,  e.rw);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int nreq;
        int res;

        //            name      op          f3    f7 z  l  lu st3 alu pcw cyc rw
        vecs.push_back(mk("addi",  7'b0010011, 3'b000, 0, 0, 0, 0, 7, 0, 0, 4, 1));
        vecs.push_back(mk("addi30",7'b0010011, 3'b000, 1, 0, 0, 0, 7, 0, 0, 4, 1));
        vecs.push_back(mk("sub",   7'b0110011, 3'b000, 1, 0, 0, 0, 6, 1, 0, 4, 1));
        vecs.push_back(mk("add",   7'b0110011, 3'b000, 0, 0, 0, 0, 6, 0, 0, 4, 1));
        vecs.push_back(mk("sll",   7'b0110011, 3'b001, 0, 0, 0, 0, 6, 5, 0, 4, 1));
        vecs.push_back(mk("slt",   7'b0110011, 3'b010, 0, 0, 0, 0, 6, 8, 0, 4, 1));
        vecs.push_back(mk("sltu",  7'b0110011, 3'b011, 0, 0, 0, 0, 6, 9, 0, 4, 1));
        vecs.push_back(mk("xor",   7'b0110011, 3'b100, 0, 0, 0, 0, 6, 4, 0, 4, 1));
        vecs.push_back(mk("sra",   7'b0110011, 3'b101, 1, 0, 0, 0, 6, 7, 0, 4, 1));
        vecs.push_back(mk("or",    7'b0110011, 3'b110, 0, 0, 0, 0, 6, 3, 0, 4, 1));
        vecs.push_back(mk("and",   7'b0110011, 3'b111, 0, 0, 0, 0, 6, 2, 0, 4, 1));
        vecs.push_back(mk("srli",  7'b0010011, 3'b101, 0, 0, 0, 0, 7, 6, 0, 4, 1));
        vecs.push_back(mk("srai",  7'b0010011, 3'b101, 1, 0, 0, 0, 7, 7, 0, 4, 1));
        vecs.push_back(mk("bne_z1",7'b1100011, 3'b001, 0, 1, 0, 0, 9, 1, 0, 3, 0));
        vecs.push_back(mk("bne_z0",7'b1100011, 3'b001, 0, 0, 0, 0, 9, 1, 1, 3, 0));
        vecs.push_back(mk("beq_z1",7'b1100011, 3'b000, 0, 1, 0, 0, 9, 1, 1, 3, 0));
        vecs.push_back(mk("blt_l1",7'b1100011, 3'b100, 0, 0, 1, 0, 9, 1, 1, 3, 0));
        vecs.push_back(mk("bge_l1",7'b1100011, 3'b101, 0, 0, 1, 0, 9, 1, 0, 3, 0));
        vecs.push_back(mk("bgeu_0",7'b1100011, 3'b111, 0, 0, 0, 0, 9, 1, 1, 3, 0));
        vecs.push_back(mk("bgeu_1",7'b1100011, 3'b111, 0, 0, 0, 1, 9, 1, 0, 3, 0));
        vecs.push_back(mk("jal",   7'b1101111, 3'b000, 0, 0, 0, 0, 10, 0, 1, 4, 1));
        vecs.push_back(mk("lui",   7'b0110111, 3'b000, 0, 0, 0, 0, 11, 10, 0, 4, 1));
        vecs.push_back(mk("lw",    7'b0000011, 3'b010, 0, 0, 0, 0, 2, 0, 0, 5, 1));
        vecs.push_back(mk("sw",    7'b0100011, 3'b010, 0, 0, 0, 0, 2, 0, 0, 4, 0));

        // Reset values, then FETCH outputs right after release
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        drive(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst.state",   int'(state_o),     0);
        chk("rst.mem_req", int'(bus.mem_req), 0);
        chk("rst.ir_write",int'(bus.ir_write),0);
        chk("rst.fault",   int'(fault),       0);
        do_reset();
        #1;
        chk("fetch.mem_req",    int'(bus.mem_req),    1);
        chk("fetch.ir_write",   int'(bus.ir_write),   0);
        chk("fetch.alu_src_b",  int'(bus.alu_src_b),  2);
        chk("fetch.result_src", int'(bus.result_src), 2);

        // mem_ready on the last counted cycle wins, then illegal opcode traps
        for (int i = 0; i < 15; i++) next_cycle();
        bus.mem_ready = 1'b1;
        #1;
        chk("lastcnt.state",    int'(state_o),      0);
        chk("lastcnt.ir_write", int'(bus.ir_write), 1);
        next_cycle();
        bus.mem_ready = 1'b0;
        #1;
        chk("lastcnt.decode", int'(state_o), 1);
        chk("lastcnt.fault",  int'(fault),   0);
        next_cycle();
        #1;
        chk("illegal.state", int'(state_o), 12);
        chk("illegal.fault", int'(fault),   1);
        bus.mem_ready = 1'b1;
        repeat (3) next_cycle();
        #1;
        chk("sticky.state",   int'(state_o),     12);
        chk("sticky.fault",   int'(fault),       1);
        chk("sticky.mem_req", int'(bus.mem_req), 0);

        // Fetch timeout: TIMEOUT cycles without ready end in TRAP
        do_reset();
        for (int i = 0; i < 16; i++) begin
            #1;
            if (i == 15) chk("tmo.still_fetch", int'(state_o), 0);
            next_cycle();
        end
        #1;
        chk("tmo.state",   int'(state_o),     12);
        chk("tmo.fault",   int'(fault),       1);
        chk("tmo.mem_req", int'(bus.mem_req), 0);

        // Instruction table
        do_reset();
        foreach (vecs[i]) run_vec(vecs[i]);

        // lw with memory ready withheld for 3 cycles in MEMRD
        drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        cyc  = 0;
        nreq = 0;
        res  = -1;
        forever begin
            #1;
            if (cyc > 0 && state_o == 4'd0) break;
            if (cyc >= 40) break;
            if (bus.mem_req && bus.adr_src) nreq++;
            if (state_o == 4'd4) res = int'(bus.result_src);
            next_cycle();
            cyc++;
            bus.mem_ready = !(cyc >= 3 && cyc <= 5);
        end
        chk("lw_wait.cycles",     cyc,  8);
        chk("lw_wait.req_cycles", nreq, 4);
        chk("lw_wait.result_src", res,  1);
        chk("lw_wait.fault",      int'(fault), 0);

        // Reset asserted while a store waits in MEMWR
        drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        chk("memwr.state",     int'(state_o),       5);
        chk("memwr.mem_write", int'(bus.mem_write), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("memwr_rst.mem_req",   int'(bus.mem_req),   0);
        chk("memwr_rst.mem_write", int'(bus.mem_write), 0);
        chk("memwr_rst.state",     int'(state_o),       0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("memwr_rel.mem_req", int'(bus.mem_req), 1);

        // Branch with reserved funct3 traps
        drive(7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        repeat (3) next_cycle();
        #1;
        chk("br010.state", int'(state_o), 12);
        chk("br010.fault", int'(fault),   1);

`ifdef MC_CU_INSTRET_EN
        do_reset();
        run_vec(vecs[0]);
        run_vec(vecs[2]);
        run_vec(vecs[13]);
        chk("instret.three", int'(instret), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
